divide_iterative: RTL and testbench



---
 rtl/divide_iterative.sv | 135 +++++++++++++
 tb/tb_divide_iterative.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/divide_iterative.sv
// Iterative restoring divider: one quotient bit per clock, signed or unsigned,
// with valid/ready handshakes on both the operand and result sides.
module divide_iterative #(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         sign,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] Q,
   output logic [N-1:0] R,
   output logic         div_by_zero
);

   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   // dq starts as |A| and turns into the quotient as bits shift in from the right
   logic [N-1:0]  dq;
   logic [N-1:0]  divisor;
   logic [N-1:0]  rem;
   logic [CW-1:0] cnt;
   logic          neg_q;
   logic          neg_r;

   logic          accept_c;
   logic [N-1:0]  mag_a_c;
   logic [N-1:0]  mag_b_c;
   logic [N:0]    rem_shift_c;
   logic [N:0]    diff_c;
   logic          q_bit_c;
   logic [N-1:0]  rem_next_c;
   logic [N-1:0]  q_final_c;

   assign accept_c = in_valid & in_ready;

   // Operand magnitudes; |most-negative| still fits as an N-bit unsigned value
   always_comb begin
      mag_a_c = A;
      mag_b_c = B;
      if (sign && A[N-1]) mag_a_c = ~A + N'(1);
      if (sign && B[N-1]) mag_b_c = ~B + N'(1);
   end

   // One restoring step; the borrow out of the trial subtraction decides the quotient bit
   always_comb begin
      rem_shift_c = {rem, dq[N-1]};
      diff_c      = rem_shift_c - {1'b0, divisor};
      q_bit_c     = ~diff_c[N];
      rem_next_c  = q_bit_c ? diff_c[N-1:0] : rem_shift_c[N-1:0];
      q_final_c   = {dq[N-2:0], q_bit_c};
   end

   // Next-state decode
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (in_valid) state_next = (B == '0) ? DONE : CALC;
         CALC: if (cnt == '0) state_next = DONE;
         DONE: if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register; handshake flags are registered copies of the next-state decode
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state     <= state_next;
         in_ready  <= (state_next == IDLE);
         out_valid <= (state_next == DONE);
      end
   end

   // Datapath: latch operands on accept, iterate in CALC, publish the signed-corrected result
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dq          <= '0;
         divisor     <= '0;
         rem         <= '0;
         cnt         <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         Q           <= '0;
         R           <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept_c) begin
                  dq      <= mag_a_c;
                  divisor <= mag_b_c;
                  rem     <= '0;
                  cnt     <= CW'(N - 1);
                  neg_q   <= sign & (A[N-1] ^ B[N-1]);
                  neg_r   <= sign & A[N-1];
                  if (B == '0) begin
                     Q           <= '1;
                     R           <= A;
                     div_by_zero <= 1'b1;
                  end
               end
            end
            CALC: begin
               dq  <= q_final_c;
               rem <= rem_next_c;
               cnt <= cnt - CW'(1);
               if (cnt == '0) begin
                  Q           <= neg_q ? (~q_final_c + N'(1)) : q_final_c;
                  R           <= neg_r ? (~rem_next_c + N'(1)) : rem_next_c;
                  div_by_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_divide_iterative.sv
// Self-checking bench for divide_iterative against an integer-arithmetic model.
module tb_divide_iterative;

   localparam int unsigned N = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         sign;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] da;
   logic [N-1:0] db;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] q;
   logic [N-1:0] r;
   logic         div_by_zero;

   int errors = 0;
   int checks = 0;

   divide_iterative #(.N(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sign       (sign),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .A          (da),
      .B          (db),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .Q          (q),
      .R          (r),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   // Reference: C-style truncating division on plain integers
   function automatic void model(input logic s, input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] mq, output logic [7:0] mr, output logic mz);
      int sa;
      int sb;
      if (b == 8'd0) begin
         mq = 8'hFF;
         mr = a;
         mz = 1'b1;
      end else if (s) begin
         sa = $signed(a);
         sb = $signed(b);
         mq = 8'(sa / sb);
         mr = 8'(sa % sb);
         mz = 1'b0;
      end else begin
         sa = int'(a);
         sb = int'(b);
         mq = 8'(sa / sb);
         mr = 8'(sa % sb);
         mz = 1'b0;
      end
   endfunction

   // Full operation: accept, latency, result, optional backpressure, output handshake
   task automatic run_op(input logic s, input logic [7:0] a, input logic [7:0] b,
                         input int hold, input logic early, input logic junk);
      logic [7:0] eq;
      logic [7:0] er;
      logic       ez;
      int         k;
      int         want_lat;
      model(s, a, b, eq, er, ez);
      want_lat = (b == 8'd0) ? 0 : N;
      k = 0;
      while (!in_ready && k < 40) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL accept_timeout: in_ready=%0b want 1", in_ready);
         return;
      end
      sign      = s;
      da        = a;
      db        = b;
      in_valid  = 1'b1;
      out_ready = early;
      @(negedge clk);
      in_valid = 1'b0;
      sign     = 1'($urandom);
      da       = 8'($urandom);
      db       = 8'($urandom);
      k = 0;
      while (!out_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (k != want_lat) begin
         errors++;
         $display("FAIL latency: got %0d want %0d (s=%0b a=%h b=%h)", k, want_lat, s, a, b);
      end
      if (!out_valid) return;
      checks++;
      if (q !== eq || r !== er || div_by_zero !== ez) begin
         errors++;
         $display("FAIL result: s=%0b a=%h b=%h got Q=%h R=%h z=%0b want Q=%h R=%h z=%0b",
                  s, a, b, q, r, div_by_zero, eq, er, ez);
      end
      if (!early) begin
         for (int i = 0; i < hold; i++) begin
            if (junk) begin
               in_valid = 1'b1;
               sign     = 1'($urandom);
               da       = 8'($urandom);
               db       = 8'($urandom);
            end
            @(negedge clk);
            checks++;
            if (q !== eq || r !== er || div_by_zero !== ez || in_ready !== 1'b0 || out_valid !== 1'b1) begin
               errors++;
               $display("FAIL hold: cyc=%0d got Q=%h R=%h z=%0b rdy=%0b ov=%0b want Q=%h R=%h z=%0b rdy=0 ov=1",
                        i, q, r, div_by_zero, in_ready, out_valid, eq, er, ez);
            end
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL out_handshake: ov=%0b rdy=%0b want ov=0 rdy=1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      sign      = 1'b1;
      da        = 8'h55;
      db        = 8'h00;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || q !== 8'h00 || r !== 8'h00 || div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset: rdy=%0b ov=%0b Q=%h R=%h z=%0b want 1 0 00 00 0",
                  in_ready, out_valid, q, r, div_by_zero);
      end
      in_valid = 1'b0;
      rst_n    = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: ov=%0b rdy=%0b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_directed();
      run_op(1'b0, 8'd200, 8'd7,   0, 1'b0, 1'b0);
      run_op(1'b1, 8'hF9,  8'h02,  0, 1'b0, 1'b0);
      run_op(1'b1, 8'h07,  8'hFE,  0, 1'b0, 1'b0);
      run_op(1'b1, 8'hF9,  8'hFE,  0, 1'b0, 1'b0);
      run_op(1'b1, 8'h80,  8'hFF,  0, 1'b0, 1'b0);
      run_op(1'b0, 8'hFF,  8'hFF,  0, 1'b0, 1'b0);
      run_op(1'b0, 8'h05,  8'h09,  0, 1'b0, 1'b0);
   endtask

   task automatic test_div_by_zero();
      run_op(1'b1, 8'h55, 8'h00, 0, 1'b0, 1'b0);
      run_op(1'b1, 8'h55, 8'h03, 0, 1'b0, 1'b0);
      run_op(1'b0, 8'hA0, 8'h00, 1, 1'b0, 1'b0);
   endtask

   task automatic test_backpressure();
      run_op(1'b0, 8'd123, 8'd11, 5, 1'b0, 1'b1);
      run_op(1'b1, 8'h9C,  8'h05, 0, 1'b0, 1'b0);
   endtask

   task automatic test_early_ready();
      run_op(1'b0, 8'd77, 8'd5, 0, 1'b1, 1'b0);
      run_op(1'b1, 8'hC4, 8'h00, 0, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid_op();
      int seen;
      sign     = 1'b0;
      da       = 8'd200;
      db       = 8'd3;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || q !== 8'h00 || r !== 8'h00) begin
         errors++;
         $display("FAIL mid_reset: ov=%0b rdy=%0b Q=%h R=%h want 0 1 00 00", out_valid, in_ready, q, r);
      end
      rst_n = 1'b1;
      seen  = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL aborted_result: out_valid cycles=%0d want 0", seen);
      end
      run_op(1'b0, 8'd100, 8'd10, 0, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      logic [7:0] a;
      logic [7:0] b;
      int         pick;
      for (int i = 0; i < 40; i++) begin
         a    = 8'($urandom);
         pick = int'($urandom_range(0, 9));
         b    = (pick == 0) ? 8'h00 : (pick == 1) ? 8'h01 : (pick == 2) ? 8'hFF : 8'($urandom);
         if (pick == 3) a = 8'h80;
         run_op(1'($urandom), a, b, int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0), 1'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_div_by_zero();
      test_backpressure();
      test_early_ready();
      test_reset_mid_op();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
